// File: rtl/blackjack_turn_controller_if.sv
// blackjack_turn_controller_if: card request/valid handshake between the round controller and the card source.
interface blackjack_turn_controller_if;
    logic       card_req;
    logic       card_valid;
    logic [3:0] card_rank;
    modport master (output card_req, input card_valid, card_rank);
    modport slave (input card_req, output card_valid, card_rank);
endinterface

// File: rtl/blackjack_turn_controller.sv
// blackjack_turn_controller: blackjack round sequencer with card handshake, ace handling and dealer draw rule.
// Optional DEALER_HITS_SOFT17_EN makes the dealer draw on soft 17.
`ifndef gameCommand
`define gameCommand [1:0]
`define COMMAND_NONE 2'd0
`define COMMAND_HIT 2'd1
`define COMMAND_STAND 2'd2
`endif
module blackjack_turn_controller #(
    parameter int DEALER_STAND_TOTAL = 17,
    parameter int TOTAL_W = 5
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_dealButtonPushed,
    input  logic                       i_ready,
    input  logic `gameCommand          i_command,
    blackjack_turn_controller_if.master card,
    output logic                       o_turnIndicator,
    output logic [TOTAL_W-1:0]         o_player_total,
    output logic [TOTAL_W-1:0]         o_dealer_total,
    output logic [3:0]                 o_player_cards,
    output logic [1:0]                 o_result
);
    typedef enum logic [3:0] {
        IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_TURN, PLAYER_DRAW,
        DEALER_TURN, DEALER_DRAW, COMPARE, RESULT
    } state_t;
    state_t state, state_n;
    logic deal_q, p_ace, d_ace, p_ace_n, d_ace_n, clear, accept, to_player, to_dealer, dealer_draw;
    logic [TOTAL_W-1:0] p_hard, d_hard, p_hard_n, d_hard_n, p_eff_n, d_eff_n, val;
    logic [3:0] p_cards_n;
    logic [1:0] result_n;

    function automatic logic [TOTAL_W-1:0] effective(input logic [TOTAL_W-1:0] hard, input logic ace);
        return (ace && hard <= TOTAL_W'(11)) ? hard + TOTAL_W'(10) : hard;
    endfunction

    assign card.card_req = state inside {DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_DRAW, DEALER_DRAW};
    assign o_turnIndicator = state == PLAYER_TURN;
    // Out-of-range ranks are dropped without advancing, so the request stays up.
    assign accept = card.card_req && card.card_valid && card.card_rank != 4'd0 && card.card_rank <= 4'd13;
    assign val = card.card_rank >= 4'd10 ? TOTAL_W'(10) : TOTAL_W'(card.card_rank);
`ifdef DEALER_HITS_SOFT17_EN
    assign dealer_draw = o_dealer_total < TOTAL_W'(DEALER_STAND_TOTAL) ||
                         (o_dealer_total == TOTAL_W'(17) && o_dealer_total != d_hard);
`else
    assign dealer_draw = o_dealer_total < TOTAL_W'(DEALER_STAND_TOTAL);
`endif

    always_comb begin
        clear = i_dealButtonPushed && !deal_q && (state == IDLE || state == RESULT);
        to_player = state inside {DEAL_P1, DEAL_P2, PLAYER_DRAW};
        to_dealer = state inside {DEAL_D1, DEAL_D2, DEALER_DRAW};
        p_hard_n = clear ? '0 : (accept && to_player) ? p_hard + val : p_hard;
        d_hard_n = clear ? '0 : (accept && to_dealer) ? d_hard + val : d_hard;
        p_ace_n = !clear && (p_ace || (accept && to_player && card.card_rank == 4'd1));
        d_ace_n = !clear && (d_ace || (accept && to_dealer && card.card_rank == 4'd1));
        p_cards_n = clear ? 4'd0 : (accept && to_player && o_player_cards != 4'hf) ? o_player_cards + 4'd1 : o_player_cards;
        p_eff_n = effective(p_hard_n, p_ace_n);
        d_eff_n = effective(d_hard_n, d_ace_n);
        state_n = state;
        result_n = clear ? 2'd0 : o_result;
        case (state)
            IDLE, RESULT: state_n = clear ? DEAL_P1 : state;
            DEAL_P1:      state_n = accept ? DEAL_D1 : state;
            DEAL_D1:      state_n = accept ? DEAL_P2 : state;
            DEAL_P2:      state_n = accept ? DEAL_D2 : state;
            DEAL_D2:      state_n = !accept ? state : o_player_total == TOTAL_W'(21) ? DEALER_TURN : PLAYER_TURN;
            PLAYER_TURN:  state_n = !i_ready ? state : i_command == `COMMAND_HIT ? PLAYER_DRAW :
                                    i_command == `COMMAND_STAND ? DEALER_TURN : state;
            PLAYER_DRAW: begin
                state_n = !accept ? state : p_hard_n > TOTAL_W'(21) ? RESULT :
                          p_eff_n == TOTAL_W'(21) ? DEALER_TURN : PLAYER_TURN;
                result_n = (accept && p_hard_n > TOTAL_W'(21)) ? 2'd2 : o_result;
            end
            DEALER_TURN:  state_n = dealer_draw ? DEALER_DRAW : COMPARE;
            DEALER_DRAW:  state_n = accept ? DEALER_TURN : state;
            COMPARE: begin
                state_n = RESULT;
                result_n = d_hard > TOTAL_W'(21) ? 2'd1 : o_player_total > o_dealer_total ? 2'd1 :
                           o_player_total < o_dealer_total ? 2'd2 : 2'd3;
            end
            default:      state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
            deal_q <= 1'b0;
            p_hard <= '0;
            d_hard <= '0;
            p_ace <= 1'b0;
            d_ace <= 1'b0;
            o_player_total <= '0;
            o_dealer_total <= '0;
            o_player_cards <= 4'd0;
            o_result <= 2'd0;
        end else begin
            state <= state_n;
            deal_q <= i_dealButtonPushed;
            p_hard <= p_hard_n;
            d_hard <= d_hard_n;
            p_ace <= p_ace_n;
            d_ace <= d_ace_n;
            o_player_total <= p_eff_n;
            o_dealer_total <= d_eff_n;
            o_player_cards <= p_cards_n;
            o_result <= result_n;
        end
    end
endmodule

// File: tb/tb_blackjack_turn_controller.sv
// tb_blackjack_turn_controller: directed rounds with hand-computed totals and results.
`ifndef gameCommand
`define gameCommand [1:0]
`define COMMAND_NONE 2'd0
`define COMMAND_HIT 2'd1
`define COMMAND_STAND 2'd2
`endif
module tb_blackjack_turn_controller;
    logic clk, reset_n, deal, ready, turn;
    logic `gameCommand cmd;
    logic [4:0] player_total, dealer_total;
    logic [3:0] player_cards;
    logic [1:0] result;
    int tests = 0, fails = 0, turn_cnt = 0, turn_mark;

    blackjack_turn_controller_if bus ();

    blackjack_turn_controller dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_dealButtonPushed(deal), .i_ready(ready),
        .i_command(cmd), .card(bus.master), .o_turnIndicator(turn),
        .o_player_total(player_total), .o_dealer_total(dealer_total),
        .o_player_cards(player_cards), .o_result(result)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (turn === 1'b1) turn_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic give_card(input logic [3:0] r);
        int n = 0;
        while (bus.card_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("card_req_wait", bus.card_req, 1);
        bus.card_valid = 1;
        bus.card_rank = r;
        @(negedge clk);
        bus.card_valid = 0;
        bus.card_rank = 0;
    endtask

    task automatic pulse_deal();
        deal = 1;
        @(negedge clk);
        deal = 0;
    endtask

    task automatic command(input logic `gameCommand c);
        ready = 1;
        cmd = c;
        @(negedge clk);
        ready = 0;
        cmd = `COMMAND_NONE;
    endtask

    initial begin
        reset_n = 0; deal = 0; ready = 0; cmd = `COMMAND_NONE;
        bus.card_valid = 0; bus.card_rank = 0;
        repeat (3) @(negedge clk);
        check("reset_req", bus.card_req, 0);
        check("reset_result", result, 0);
        check("reset_ptotal", player_total, 0);
        reset_n = 1;
        @(negedge clk);
        // Round 1: player 17 stands against dealer 19
        pulse_deal();
        check("r1_req", bus.card_req, 1);
        give_card(10); give_card(9); give_card(7); give_card(10);
        check("r1_turn", turn, 1);
        check("r1_ptotal", player_total, 17);
        check("r1_dtotal", dealer_total, 19);
        check("r1_pcards", player_cards, 2);
        command(`COMMAND_STAND);
        check("r1_turn_drop", turn, 0);
        repeat (3) @(negedge clk);
        check("r1_result", result, 2);
        check("r1_req_idle", bus.card_req, 0);
        // Round 2: player blackjack auto-stands, dealer 16 draws 5, push
        turn_mark = turn_cnt;
        pulse_deal();
        check("r2_clear_ptotal", player_total, 0);
        check("r2_clear_result", result, 0);
        give_card(1); give_card(10); give_card(13); give_card(6);
        check("r2_ptotal", player_total, 21);
        check("r2_dtotal", dealer_total, 16);
        give_card(5);
        repeat (3) @(negedge clk);
        check("r2_dtotal_final", dealer_total, 21);
        check("r2_result", result, 3);
        check("r2_no_turn", turn_cnt - turn_mark, 0);
        // Round 3: deal held high throughout, player busts on a hit
        deal = 1;
        @(negedge clk);
        give_card(10); give_card(5); give_card(6); give_card(9);
        check("r3_ptotal", player_total, 16);
        check("r3_dtotal", dealer_total, 14);
        command(`COMMAND_HIT);
        check("r3_draw_req", bus.card_req, 1);
        bus.card_valid = 1; bus.card_rank = 14;
        @(negedge clk);
        bus.card_valid = 0; bus.card_rank = 0;
        check("r3_bad_rank_req", bus.card_req, 1);
        check("r3_bad_rank_total", player_total, 16);
        check("r3_bad_rank_cards", player_cards, 2);
        give_card(9);
        check("r3_bust_result", result, 2);
        check("r3_bust_ptotal", player_total, 25);
        check("r3_bust_dtotal", dealer_total, 14);
        check("r3_pcards", player_cards, 3);
        repeat (10) @(negedge clk);
        check("r3_held_req", bus.card_req, 0);
        check("r3_held_result", result, 2);
        deal = 0;
        @(negedge clk);
        // Round 4: stalled card source, then dealer soft 17
        pulse_deal();
        give_card(10);
        repeat (50) @(negedge clk);
        check("r4_stall_req", bus.card_req, 1);
        check("r4_stall_cards", player_cards, 1);
        check("r4_stall_dtotal", dealer_total, 0);
        give_card(1); give_card(7); give_card(6);
        check("r4_turn", turn, 1);
        check("r4_ptotal", player_total, 17);
        check("r4_dtotal_soft", dealer_total, 17);
        command(`COMMAND_STAND);
`ifdef DEALER_HITS_SOFT17_EN
        give_card(10);
`endif
        repeat (5) @(negedge clk);
        check("r4_req_done", bus.card_req, 0);
        check("r4_dtotal", dealer_total, 17);
        check("r4_result", result, 3);
        // Round 5: reset in the middle of a player draw
        pulse_deal();
        give_card(2); give_card(3); give_card(4); give_card(5);
        check("r5_ptotal", player_total, 6);
        command(`COMMAND_HIT);
        check("r5_draw_req", bus.card_req, 1);
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        check("r5_rst_req", bus.card_req, 0);
        check("r5_rst_ptotal", player_total, 0);
        check("r5_rst_dtotal", dealer_total, 0);
        check("r5_rst_cards", player_cards, 0);
        check("r5_rst_turn", turn, 0);
        pulse_deal();
        check("r5_redeal_req", bus.card_req, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/blackjack_turn_controller.md
Name: blackjack_turn_controller

Overview:
- Round sequencer directly downstream of the button-input stage.
- Consumes the debounced deal pulse, ready strobe and `gameCommand` from that stage, and drives the turn indicator back to it.
- Requests cards from the deck/card source through a req/valid handshake, and accumulates player and dealer totals with ace handling.
- Runs the dealer's draw rule and publishes the round result for display.

Parameters:
DEALER_STAND_TOTAL  17  dealer stops drawing at effective total >= this value
TOTAL_W  5  width of the hard and effective totals (max hard sum 30 fits)

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  synchronous reset, active-low
i_dealButtonPushed  input  1  debounced deal button level
i_ready  input  1  command strobe qualifier from the input stage
i_command  input  `gameCommand  COMMAND_NONE / COMMAND_HIT / COMMAND_STAND, compared by macro name only
i_card_valid  input  1  card source presents a card
i_card_rank  input  4  card rank, 1=A, 2..10, 11..13=J/Q/K
o_card_req  output  1  card request, held until accepted
o_turnIndicator  output  1  high only while the player may act
o_player_total  output  TOTAL_W  player effective total
o_dealer_total  output  TOTAL_W  dealer effective total
o_player_cards  output  4  cards held by the player, saturates at 15
o_result  output  2  0=none, 1=player win, 2=dealer win, 3=push

Behaviour:
- Clock and reset:
  - Single clock domain; everything is sampled on the rising edge of i_clk.
  - i_reset_n=0 at any edge, including mid-round, forces IDLE.
  - Reset values: all outputs 0; hard sums, ace flags, card counts and deal-edge register cleared.
- Deal edge: deal_edge = i_dealButtonPushed & ~deal_q, where deal_q is the registered previous level. A held button never retriggers.
- Card value: rank 1 -> 1 (ace flag set); 2..10 -> face value; 11..13 -> 10.
- Effective total: hard + 10 if the ace flag is set and hard+10 <= 21, otherwise hard. Computed combinationally from registers; outputs are registered.
- Card handshake:
  - o_card_req=1 in every DRAW/DEAL state.
  - A card is accepted on the edge where o_card_req & i_card_valid.
  - o_card_req drops the cycle after acceptance.
  - Rank 0 or 14..15: the card is discarded, o_card_req stays high and no state change occurs.
- States and transitions:
  - IDLE: deal_edge -> clear totals, counts and o_result, then go to DEAL_P1.
  - DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2: each state accepts one card into the named hand and advances on acceptance.
  - After DEAL_D2: player effective total == 21 -> DEALER_TURN (auto-stand); otherwise PLAYER_TURN.
  - PLAYER_TURN: o_turnIndicator=1.
    - i_ready & COMMAND_HIT -> PLAYER_DRAW.
    - i_ready & COMMAND_STAND -> DEALER_TURN.
    - Any other input: hold.
    - Both conditions can never be true at once because the command is single-valued.
  - PLAYER_DRAW: on acceptance:
    - hard sum > 21 -> RESULT with o_result=2 (dealer not drawn);
    - effective total == 21 -> DEALER_TURN;
    - otherwise -> PLAYER_TURN.
  - DEALER_TURN: one decision cycle.
    - Dealer effective total < DEALER_STAND_TOTAL -> DEALER_DRAW; otherwise COMPARE.
  - DEALER_DRAW: on acceptance -> DEALER_TURN.
  - COMPARE, one cycle:
    - dealer hard > 21 -> result 1;
    - player > dealer -> 1;
    - player < dealer -> 2;
    - equal -> 3.
    - Then go to RESULT.
  - RESULT: totals and o_result held stable. deal_edge -> same clearing as IDLE, then DEAL_P1.
- Command inputs are ignored outside PLAYER_TURN. Deal edges are ignored outside IDLE and RESULT.
- o_turnIndicator deasserts the cycle after the state leaves PLAYER_TURN, so a lingering i_ready cannot issue a second command.
- No overflow: the maximum hard sum is 20+10=30, which fits TOTAL_W=5.

Optional Feature:
- Macro: DEALER_HITS_SOFT17_EN.
- Defined: in DEALER_TURN the dealer also draws when the effective total == 17 and the ace's +10 is applied (soft 17).
- Undefined: the dealer stands on any total >= DEALER_STAND_TOTAL, soft or hard.

Test Plan:
- Reset mid-PLAYER_DRAW with o_card_req=1 -> next cycle IDLE, all outputs 0, o_card_req=0.
- Deal edge; cards 10,9,7,10 (P,D,P,D); STAND -> dealer 19 stands, COMPARE: player 17 < 19 -> o_result=2.
- Deal; cards 1,10,13,6 -> player effective 21 after DEAL_P2, auto-stand with no o_turnIndicator pulse; dealer 16 draws, card 5 -> 21, push, o_result=3.
- Player 10,6, HIT with card 9 -> hard 25, RESULT, o_result=2, dealer total stays at its two-card value.
- Dealer cards 1,6 (soft 17): without macro the dealer stands at 17; with DEALER_HITS_SOFT17_EN it draws, card 10 -> hard 17, then stands.
- i_card_valid held low 50 cycles in DEAL_D1 -> o_card_req stays 1 and the state holds. Rank 14 presented -> discarded with no total change. Held deal button in RESULT -> exactly one new round.
